lstm_cell_update: RTL and testbench
===================================

# lstm_cell_update

Per-element LSTM state update stage, fed by the gate/network sequencer. It consumes the stored pre-activation gate values for one hidden element (f, then i and g, then o) and the previous cell state c_pre. It produces c_new, which is written back to the cell memory, and h_new, which is collected into the hidden-state word. All arithmetic is signed fixed point with hard (piecewise-linear) activations, and the stage is pipelined so consecutive elements overlap.

## Interface
- WL, 16, data word length (two's complement)
- FRAC, 8, fractional bits; 1.0 = 2^FRAC; requires 1 ≤ FRAC ≤ WL-3
- HID, 64, hidden elements per step; element counter wraps at HID

- clk  in  1  single clock; all logic on rising edge
- rst_n  in  1  reset, synchronous, active-low
- f_done  in  1  strobe: mem_net1 holds f pre-activation this cycle
- i_done  in  1  strobe: mem_net1 = i, mem_net2 = g pre-activation this cycle
- o_done  in  1  strobe: mem_net1 holds o pre-activation this cycle
- mem_net1  in  WL  gate value port 1
- mem_net2  in  WL  gate value port 2
- c_pre  in  WL  previous cell state, sampled with f_done
- c_new  out  WL  updated cell state, held until next update
- c_valid  out  1  one-cycle pulse when c_new updates
- h_new  out  WL  new hidden value, held until next update
- h_valid  out  1  one-cycle pulse when h_new updates
- cell_idx  out  log2(HID)  index of the element whose h_new is current
- step_done  out  1  one-cycle pulse with the HID-th h_valid
- seq_err  out  1  sticky protocol-error flag, cleared only by reset

## Operation
- Activation functions:
  - hsig(x) = clamp((x>>>2) + 2^(FRAC-1), 0, 2^FRAC)
  - htanh(x) = clamp(x, -2^FRAC, 2^FRAC)
- Multiply: full 2WL-bit signed product, arithmetic shift right by FRAC (rounds toward −∞), then saturate to WL bits.
- Add: WL+1-bit sum, saturated to WL bits.
- FSM states and transitions:
  - S_WAIT_F: on f_done, register fc = mul(hsig(mem_net1), c_pre) → S_WAIT_I.
  - S_WAIT_I: on i_done, register ig = mul(hsig(mem_net1), htanh(mem_net2)) → S_SUM.
  - S_SUM: unconditional; c_new = add(fc, ig); c_valid = 1 → S_WAIT_O.
  - S_WAIT_O: on o_done, h_new = mul(hsig(mem_net1), htanh(c_new)); h_valid = 1; cell_idx increments; → S_WAIT_F.
- Overlap in S_WAIT_O: if f_done and o_done arrive together, both are processed. h_new is completed and the FSM goes to S_WAIT_I with the new fc.
- Protocol errors (each sets seq_err):
  - Strobe arriving in a state that does not expect it: ignored.
  - f_done in S_WAIT_I: restarts the element with the new f; the old fc is discarded.
  - f_done together with i_done: treated as f_done only.
- Element counter:
  - cell_idx counts completed elements, 0..HID-1, wrapping to 0.
  - step_done pulses with the h_valid whose cell_idx is HID-1.

## Timing
- Every state-changing strobe is sampled at rising edge k.
- fc and ig are registered at edge k.
- c_new/c_valid are registered at edge k+1 after i_done (c_valid high for exactly one cycle).
- h_new/h_valid are registered at edge k after o_done.
- o_done is honoured no earlier than 2 cycles after i_done. An earlier o_done finds the FSM in S_SUM, so it is ignored and seq_err is set.
- Minimum element period: 3 cycles when f and o overlap.
- Reset values (rst_n = 0 at an edge):
  - FSM → S_WAIT_F
  - c_new, h_new, fc, ig, cell_idx = 0
  - c_valid, h_valid, step_done, seq_err = 0
- Reset mid-element discards all partial state. The strobes in the reset cycle are ignored.

## Structure
- Package lstm_fx_pkg holds:
  - FSM state enum
  - constants ONE = 2^FRAC and HALF = 2^(FRAC-1)
  - saturate-to-WL and fixed-point multiply functions
- Sub-module lstm_hard_act: combinational; a mode input selects hsig or htanh. It is instantiated four times, for f/i/o and for g/c_new tanh.
- Datapath registers and FSM live in lstm_cell_update.

## Test plan
All values use WL=16, FRAC=8.
- Nominal: f=0, c_pre=512; i=0, g=256; o=0.
  - c_new = 384 with c_valid 2 edges after i_done.
  - h_new = 128 one edge after o_done.
- Saturation: f=2048, c_pre=32767, i=2048, g=1024.
  - fc = 32767, ig = 256, so c_new saturates to 32767.
  - o=2048 gives h_new = 256.
- Negative path: f=-2048 (hsig=0), c_pre=1000; i=0, g=-1024.
  - c_new = -128.
  - o=0 gives h_new = -64.
- Back-to-back: 64 elements at minimum period, with f_done coincident with each o_done.
  - 64 h_valid pulses; cell_idx runs 0..63.
  - step_done is coincident with the last pulse; seq_err stays 0.
- Protocol errors:
  - i_done in S_WAIT_F → seq_err = 1, no c_valid.
  - o_done 1 cycle after i_done → seq_err = 1, no h_valid.
- Reset mid-element: rst_n low for 1 cycle between i_done and c_valid.
  - No c_valid; all outputs 0.
  - The next full element yields correct values.

Source files
------------

// File: rtl/lstm_fx_pkg.sv
// Fixed-point constants, FSM/activation enums and saturating arithmetic helpers
// shared by the LSTM cell-update stage.
package lstm_fx_pkg;

  localparam int unsigned WL    = 16;
  localparam int unsigned FRAC  = 8;
  localparam int unsigned HID   = 64;
  localparam int unsigned IDX_W = $clog2(HID);
  localparam int unsigned PW    = 2 * WL;
  localparam int unsigned SW    = WL + 1;

  localparam logic signed [WL-1:0] ONE     = WL'(1 << FRAC);
  localparam logic signed [WL-1:0] HALF    = WL'(1 << (FRAC - 1));
  localparam logic signed [WL-1:0] NEG_ONE = WL'(-(1 << FRAC));

  typedef enum logic [1:0] {
    S_WAIT_F,
    S_WAIT_I,
    S_SUM,
    S_WAIT_O
  } state_e;

  typedef enum logic {
    ACT_HSIG,
    ACT_HTANH
  } act_mode_e;

  // Clamp a wide signed value into WL bits; fits when all bits above WL-1 are sign copies.
  function automatic logic signed [WL-1:0] sat_wl(input logic signed [PW-1:0] x);
    if (x[PW-1:WL-1] == {(PW-WL+1){x[PW-1]}}) begin
      return x[WL-1:0];
    end
    return x[PW-1] ? {1'b1, {(WL-1){1'b0}}} : {1'b0, {(WL-1){1'b1}}};
  endfunction

  // Full-precision product, floor-shifted back to FRAC fractional bits.
  function automatic logic signed [WL-1:0] fx_mul(input logic signed [WL-1:0] a,
                                                   input logic signed [WL-1:0] b);
    logic signed [PW-1:0] p;
    p = PW'(a) * PW'(b);
    return sat_wl(p >>> FRAC);
  endfunction

  function automatic logic signed [WL-1:0] fx_add(input logic signed [WL-1:0] a,
                                                   input logic signed [WL-1:0] b);
    logic signed [SW-1:0] s;
    s = SW'(a) + SW'(b);
    return sat_wl(PW'(s));
  endfunction

endpackage

// File: rtl/lstm_cell_update_if.sv
// Sequencer <-> cell-update stage bundle: gate strobes/values in, cell/hidden results out.
interface lstm_cell_update_if;
  import lstm_fx_pkg::*;

  logic                    f_done;
  logic                    i_done;
  logic                    o_done;
  logic signed [WL-1:0]    mem_net1;
  logic signed [WL-1:0]    mem_net2;
  logic signed [WL-1:0]    c_pre;
  logic signed [WL-1:0]    c_new;
  logic                    c_valid;
  logic signed [WL-1:0]    h_new;
  logic                    h_valid;
  logic [IDX_W-1:0]        cell_idx;
  logic                    step_done;
  logic                    seq_err;

  modport master (
    output f_done, i_done, o_done, mem_net1, mem_net2, c_pre,
    input  c_new, c_valid, h_new, h_valid, cell_idx, step_done, seq_err
  );

  modport slave (
    input  f_done, i_done, o_done, mem_net1, mem_net2, c_pre,
    output c_new, c_valid, h_new, h_valid, cell_idx, step_done, seq_err
  );

endinterface

// File: rtl/lstm_hard_act.sv
// Combinational piecewise-linear activation: hard sigmoid or hard tanh by mode.
module lstm_hard_act
  import lstm_fx_pkg::*;
(
  input  act_mode_e             mode,
  input  logic signed [WL-1:0]  x,
  output logic signed [WL-1:0]  y_c
);

  logic signed [WL-1:0] lin;

  // x>>>2 plus one half cannot overflow WL bits, so clamp directly on lin.
  always_comb begin
    lin = x;
    y_c = x;
    if (mode == ACT_HSIG) begin
      lin = (x >>> 2) + HALF;
      if (lin[WL-1]) begin
        y_c = '0;
      end else if (lin > ONE) begin
        y_c = ONE;
      end else begin
        y_c = lin;
      end
    end else begin
      if (x > ONE) begin
        y_c = ONE;
      end else if (x < NEG_ONE) begin
        y_c = NEG_ONE;
      end else begin
        y_c = x;
      end
    end
  end

endmodule

// File: rtl/lstm_cell_update.sv
// Per-element LSTM cell/hidden update: c = f*c_pre + i*g, h = o*tanh(c), pipelined
// so the next element's f can land in the same cycle as this element's o.
module lstm_cell_update
  import lstm_fx_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  lstm_cell_update_if.slave  bus
);

  state_e                state, state_n;
  logic signed [WL-1:0]  fc, fc_n;
  logic signed [WL-1:0]  ig, ig_n;
  logic signed [WL-1:0]  c_new_q, c_new_n;
  logic signed [WL-1:0]  h_new_q, h_new_n;
  logic                  c_valid_q, c_valid_n;
  logic                  h_valid_q, h_valid_n;
  logic                  step_done_q, step_done_n;
  logic                  seq_err_q, seq_err_n;
  logic [IDX_W-1:0]      elem_cnt, elem_cnt_n;
  logic [IDX_W-1:0]      cell_idx_q, cell_idx_n;

  logic signed [WL-1:0]  sig_fi_c, sig_o_c, tanh_g_c, tanh_c_c;
  logic signed [WL-1:0]  fc_calc_c, ig_calc_c, h_calc_c, sum_c;

  lstm_hard_act u_act_fi (.mode(ACT_HSIG),  .x(bus.mem_net1), .y_c(sig_fi_c));
  lstm_hard_act u_act_o  (.mode(ACT_HSIG),  .x(bus.mem_net1), .y_c(sig_o_c));
  lstm_hard_act u_act_g  (.mode(ACT_HTANH), .x(bus.mem_net2), .y_c(tanh_g_c));
  lstm_hard_act u_act_c  (.mode(ACT_HTANH), .x(c_new_q),      .y_c(tanh_c_c));

  assign fc_calc_c = fx_mul(sig_fi_c, bus.c_pre);
  assign ig_calc_c = fx_mul(sig_fi_c, tanh_g_c);
  assign h_calc_c  = fx_mul(sig_o_c, tanh_c_c);
  assign sum_c     = fx_add(fc, ig);

  // Next-state and datapath update; unexpected strobes only raise seq_err.
  always_comb begin
    state_n     = state;
    fc_n        = fc;
    ig_n        = ig;
    c_new_n     = c_new_q;
    c_valid_n   = 1'b0;
    h_new_n     = h_new_q;
    h_valid_n   = 1'b0;
    elem_cnt_n  = elem_cnt;
    cell_idx_n  = cell_idx_q;
    step_done_n = 1'b0;
    seq_err_n   = seq_err_q;

    case (state)
      S_WAIT_F: begin
        if (bus.i_done || bus.o_done) seq_err_n = 1'b1;
        if (bus.f_done) begin
          fc_n    = fc_calc_c;
          state_n = S_WAIT_I;
        end
      end
      S_WAIT_I: begin
        if (bus.o_done) seq_err_n = 1'b1;
        // A fresh f restarts the element and wins over a coincident i.
        if (bus.f_done) begin
          fc_n      = fc_calc_c;
          seq_err_n = 1'b1;
        end else if (bus.i_done) begin
          ig_n    = ig_calc_c;
          state_n = S_SUM;
        end
      end
      S_SUM: begin
        if (bus.f_done || bus.i_done || bus.o_done) seq_err_n = 1'b1;
        c_new_n   = sum_c;
        c_valid_n = 1'b1;
        state_n   = S_WAIT_O;
      end
      S_WAIT_O: begin
        if (bus.i_done) seq_err_n = 1'b1;
        if (bus.o_done) begin
          h_new_n     = h_calc_c;
          h_valid_n   = 1'b1;
          cell_idx_n  = elem_cnt;
          step_done_n = (elem_cnt == IDX_W'(HID - 1));
          elem_cnt_n  = (elem_cnt == IDX_W'(HID - 1)) ? '0 : elem_cnt + IDX_W'(1);
          state_n     = S_WAIT_F;
          if (bus.f_done) begin
            fc_n    = fc_calc_c;
            state_n = S_WAIT_I;
          end
        end else if (bus.f_done) begin
          seq_err_n = 1'b1;
        end
      end
      default: state_n = S_WAIT_F;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= S_WAIT_F;
      fc          <= '0;
      ig          <= '0;
      c_new_q     <= '0;
      c_valid_q   <= 1'b0;
      h_new_q     <= '0;
      h_valid_q   <= 1'b0;
      elem_cnt    <= '0;
      cell_idx_q  <= '0;
      step_done_q <= 1'b0;
      seq_err_q   <= 1'b0;
    end else begin
      state       <= state_n;
      fc          <= fc_n;
      ig          <= ig_n;
      c_new_q     <= c_new_n;
      c_valid_q   <= c_valid_n;
      h_new_q     <= h_new_n;
      h_valid_q   <= h_valid_n;
      elem_cnt    <= elem_cnt_n;
      cell_idx_q  <= cell_idx_n;
      step_done_q <= step_done_n;
      seq_err_q   <= seq_err_n;
    end
  end

  assign bus.c_new     = c_new_q;
  assign bus.c_valid   = c_valid_q;
  assign bus.h_new     = h_new_q;
  assign bus.h_valid   = h_valid_q;
  assign bus.cell_idx  = cell_idx_q;
  assign bus.step_done = step_done_q;
  assign bus.seq_err   = seq_err_q;

endmodule

// File: tb/tb_lstm_cell_update.sv
// Directed bench for lstm_cell_update with hand-computed fixed-point results (WL=16, FRAC=8).
module tb_lstm_cell_update;

  logic clk = 1'b0;
  logic rst_n;
  int   n_checks = 0;
  int   n_fail   = 0;

  lstm_cell_update_if bus ();

  lstm_cell_update dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // One clock: drive inputs, take the edge, settle, drop strobes.
  task automatic cyc(input logic f, input logic i, input logic o,
                     input logic signed [15:0] n1, input logic signed [15:0] n2,
                     input logic signed [15:0] cp);
    bus.f_done   = f;
    bus.i_done   = i;
    bus.o_done   = o;
    bus.mem_net1 = n1;
    bus.mem_net2 = n2;
    bus.c_pre    = cp;
    @(posedge clk);
    #1;
    bus.f_done = 1'b0;
    bus.i_done = 1'b0;
    bus.o_done = 1'b0;
  endtask

  task automatic idle();
    cyc(1'b0, 1'b0, 1'b0, 16'sd0, 16'sd0, 16'sd0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    idle();
    idle();
    rst_n = 1'b1;
  endtask

  // Full element at relaxed spacing; returns c/h as seen on their valid pulses.
  task automatic elem(input logic signed [15:0] nf, input logic signed [15:0] cp,
                      input logic signed [15:0] ni, input logic signed [15:0] ng,
                      input logic signed [15:0] no,
                      output logic signed [15:0] c_seen, output logic cv,
                      output logic signed [15:0] h_seen, output logic hv);
    cyc(1'b1, 1'b0, 1'b0, nf, 16'sd0, cp);
    cyc(1'b0, 1'b1, 1'b0, ni, ng, 16'sd0);
    idle();
    c_seen = bus.c_new;
    cv     = bus.c_valid;
    idle();
    cyc(1'b0, 1'b0, 1'b1, no, 16'sd0, 16'sd0);
    h_seen = bus.h_new;
    hv     = bus.h_valid;
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++;
    if (bus.c_new !== 16'sd0 || bus.h_new !== 16'sd0) begin
      n_fail++;
      $display("FAIL reset_data: c_new=%0d h_new=%0d expected 0/0", bus.c_new, bus.h_new);
    end
    n_checks++;
    if (bus.c_valid !== 1'b0 || bus.h_valid !== 1'b0 || bus.step_done !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_pulses: c_valid=%b h_valid=%b step_done=%b expected 000",
               bus.c_valid, bus.h_valid, bus.step_done);
    end
    n_checks++;
    if (bus.cell_idx !== 6'd0 || bus.seq_err !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl: cell_idx=%0d seq_err=%b expected 0/0", bus.cell_idx, bus.seq_err);
    end
  endtask

  task automatic test_nominal();
    cyc(1'b1, 1'b0, 1'b0, 16'sd0, 16'sd0, 16'sd512);
    cyc(1'b0, 1'b1, 1'b0, 16'sd0, 16'sd256, 16'sd0);
    n_checks++;
    if (bus.c_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL nominal_c_valid_early: got %b expected 0", bus.c_valid);
    end
    idle();
    n_checks++;
    if (bus.c_valid !== 1'b1 || bus.c_new !== 16'sd384) begin
      n_fail++;
      $display("FAIL nominal_c_new: c_valid=%b c_new=%0d expected 1/384", bus.c_valid, bus.c_new);
    end
    idle();
    n_checks++;
    if (bus.c_valid !== 1'b0 || bus.c_new !== 16'sd384) begin
      n_fail++;
      $display("FAIL nominal_c_hold: c_valid=%b c_new=%0d expected 0/384", bus.c_valid, bus.c_new);
    end
    cyc(1'b0, 1'b0, 1'b1, 16'sd0, 16'sd0, 16'sd0);
    n_checks++;
    if (bus.h_valid !== 1'b1 || bus.h_new !== 16'sd128 || bus.cell_idx !== 6'd0) begin
      n_fail++;
      $display("FAIL nominal_h_new: h_valid=%b h_new=%0d idx=%0d expected 1/128/0",
               bus.h_valid, bus.h_new, bus.cell_idx);
    end
    idle();
    n_checks++;
    if (bus.h_valid !== 1'b0 || bus.h_new !== 16'sd128 || bus.seq_err !== 1'b0) begin
      n_fail++;
      $display("FAIL nominal_h_hold: h_valid=%b h_new=%0d seq_err=%b expected 0/128/0",
               bus.h_valid, bus.h_new, bus.seq_err);
    end
  endtask

  task automatic test_saturation();
    logic signed [15:0] c, h;
    logic cv, hv;
    elem(16'sd2048, 16'sd32767, 16'sd2048, 16'sd1024, 16'sd2048, c, cv, h, hv);
    n_checks++;
    if (cv !== 1'b1 || c !== 16'sd32767) begin
      n_fail++;
      $display("FAIL sat_c_new: c_valid=%b c_new=%0d expected 1/32767", cv, c);
    end
    n_checks++;
    if (hv !== 1'b1 || h !== 16'sd256 || bus.cell_idx !== 6'd1) begin
      n_fail++;
      $display("FAIL sat_h_new: h_valid=%b h_new=%0d idx=%0d expected 1/256/1", hv, h, bus.cell_idx);
    end
  endtask

  task automatic test_negative();
    logic signed [15:0] c, h;
    logic cv, hv;
    elem(-16'sd2048, 16'sd1000, 16'sd0, -16'sd1024, 16'sd0, c, cv, h, hv);
    n_checks++;
    if (cv !== 1'b1 || c !== -16'sd128) begin
      n_fail++;
      $display("FAIL neg_c_new: c_valid=%b c_new=%0d expected 1/-128", cv, c);
    end
    n_checks++;
    if (hv !== 1'b1 || h !== -16'sd64 || bus.cell_idx !== 6'd2 || bus.seq_err !== 1'b0) begin
      n_fail++;
      $display("FAIL neg_h_new: h_valid=%b h_new=%0d idx=%0d seq_err=%b expected 1/-64/2/0",
               hv, h, bus.cell_idx, bus.seq_err);
    end
  endtask

  task automatic test_back_to_back();
    int pulses = 0;
    int steps  = 0;
    do_reset();
    cyc(1'b1, 1'b0, 1'b0, 16'sd0, 16'sd0, 16'sd512);
    for (int e = 0; e < 64; e++) begin
      cyc(1'b0, 1'b1, 1'b0, 16'sd0, 16'sd256, 16'sd0);
      if (bus.h_valid) pulses++;
      if (bus.step_done) steps++;
      idle();
      if (bus.h_valid) pulses++;
      if (bus.step_done) steps++;
      cyc(e < 63, 1'b0, 1'b1, 16'sd0, 16'sd0, 16'sd512);
      if (bus.h_valid) pulses++;
      if (bus.step_done) steps++;
      n_checks++;
      if (bus.h_valid !== 1'b1 || bus.cell_idx !== 6'(e) || bus.h_new !== 16'sd128 ||
          bus.step_done !== (e == 63)) begin
        n_fail++;
        $display("FAIL b2b_elem%0d: h_valid=%b idx=%0d h_new=%0d step_done=%b expected 1/%0d/128/%b",
                 e, bus.h_valid, bus.cell_idx, bus.h_new, bus.step_done, e, e == 63);
      end
    end
    idle();
    if (bus.h_valid) pulses++;
    if (bus.step_done) steps++;
    n_checks++;
    if (pulses != 64) begin
      n_fail++;
      $display("FAIL b2b_pulses: got %0d expected 64", pulses);
    end
    n_checks++;
    if (steps != 1) begin
      n_fail++;
      $display("FAIL b2b_step_done_count: got %0d expected 1", steps);
    end
    n_checks++;
    if (bus.seq_err !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_seq_err: got %b expected 0", bus.seq_err);
    end
  endtask

  task automatic test_protocol();
    int cvs = 0;
    int hvs = 0;
    do_reset();
    cyc(1'b0, 1'b1, 1'b0, 16'sd0, 16'sd256, 16'sd0);
    n_checks++;
    if (bus.seq_err !== 1'b1) begin
      n_fail++;
      $display("FAIL proto_i_in_wait_f: seq_err=%b expected 1", bus.seq_err);
    end
    for (int k = 0; k < 3; k++) begin
      idle();
      if (bus.c_valid) cvs++;
    end
    n_checks++;
    if (cvs != 0) begin
      n_fail++;
      $display("FAIL proto_i_no_c_valid: c_valid pulses=%0d expected 0", cvs);
    end

    do_reset();
    cyc(1'b1, 1'b0, 1'b0, 16'sd0, 16'sd0, 16'sd512);
    cyc(1'b0, 1'b1, 1'b0, 16'sd0, 16'sd256, 16'sd0);
    cyc(1'b0, 1'b0, 1'b1, 16'sd0, 16'sd0, 16'sd0);
    n_checks++;
    if (bus.seq_err !== 1'b1 || bus.h_valid !== 1'b0 || bus.c_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL proto_early_o: seq_err=%b h_valid=%b c_valid=%b expected 1/0/1",
               bus.seq_err, bus.h_valid, bus.c_valid);
    end
    for (int k = 0; k < 3; k++) begin
      idle();
      if (bus.h_valid) hvs++;
    end
    n_checks++;
    if (hvs != 0) begin
      n_fail++;
      $display("FAIL proto_early_o_no_h: h_valid pulses=%0d expected 0", hvs);
    end
  endtask

  task automatic test_restart();
    do_reset();
    cyc(1'b1, 1'b0, 1'b0, 16'sd2048, 16'sd0, 16'sd512);
    cyc(1'b1, 1'b0, 1'b0, 16'sd0, 16'sd0, 16'sd512);
    n_checks++;
    if (bus.seq_err !== 1'b1) begin
      n_fail++;
      $display("FAIL restart_seq_err: got %b expected 1", bus.seq_err);
    end
    // Coincident f/i: the f wins, so element restarts again with fc=256.
    cyc(1'b1, 1'b1, 1'b0, 16'sd0, 16'sd1024, 16'sd512);
    cyc(1'b0, 1'b1, 1'b0, 16'sd0, 16'sd256, 16'sd0);
    idle();
    n_checks++;
    if (bus.c_valid !== 1'b1 || bus.c_new !== 16'sd384) begin
      n_fail++;
      $display("FAIL restart_c_new: c_valid=%b c_new=%0d expected 1/384", bus.c_valid, bus.c_new);
    end
  endtask

  task automatic test_reset_mid();
    logic signed [15:0] c, h;
    logic cv, hv;
    int cvs = 0;
    do_reset();
    elem(16'sd0, 16'sd512, 16'sd0, 16'sd256, 16'sd0, c, cv, h, hv);
    elem(16'sd0, 16'sd512, 16'sd0, 16'sd256, 16'sd0, c, cv, h, hv);
    cyc(1'b1, 1'b0, 1'b0, 16'sd0, 16'sd0, 16'sd512);
    cyc(1'b0, 1'b1, 1'b0, 16'sd0, 16'sd256, 16'sd0);
    rst_n = 1'b0;
    idle();
    rst_n = 1'b1;
    n_checks++;
    if (bus.c_valid !== 1'b0 || bus.c_new !== 16'sd0 || bus.h_new !== 16'sd0) begin
      n_fail++;
      $display("FAIL midrst_data: c_valid=%b c_new=%0d h_new=%0d expected 0/0/0",
               bus.c_valid, bus.c_new, bus.h_new);
    end
    n_checks++;
    if (bus.cell_idx !== 6'd0 || bus.seq_err !== 1'b0 || bus.h_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL midrst_ctrl: idx=%0d seq_err=%b h_valid=%b expected 0/0/0",
               bus.cell_idx, bus.seq_err, bus.h_valid);
    end
    for (int k = 0; k < 2; k++) begin
      idle();
      if (bus.c_valid) cvs++;
    end
    n_checks++;
    if (cvs != 0) begin
      n_fail++;
      $display("FAIL midrst_no_c_valid: c_valid pulses=%0d expected 0", cvs);
    end
    elem(16'sd2048, 16'sd32767, 16'sd2048, 16'sd1024, 16'sd2048, c, cv, h, hv);
    n_checks++;
    if (cv !== 1'b1 || c !== 16'sd32767 || hv !== 1'b1 || h !== 16'sd256 || bus.cell_idx !== 6'd0) begin
      n_fail++;
      $display("FAIL midrst_next_elem: c_valid=%b c=%0d h_valid=%b h=%0d idx=%0d expected 1/32767/1/256/0",
               cv, c, hv, h, bus.cell_idx);
    end
  endtask

  initial begin
    rst_n        = 1'b0;
    bus.f_done   = 1'b0;
    bus.i_done   = 1'b0;
    bus.o_done   = 1'b0;
    bus.mem_net1 = '0;
    bus.mem_net2 = '0;
    bus.c_pre    = '0;
    test_reset();
    test_nominal();
    test_saturation();
    test_negative();
    test_back_to_back();
    test_protocol();
    test_restart();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
